// File: rtl/m_spi_pkg.sv
// m_spi_pkg: constants and types shared by the DAC serial link receiver
// and the DDS generator that drives the link.
//   FRAME_BITS_DEF : default number of data bits per SYNC-low window
//   SCLK_DIV       : CLK30 cycles per SCLK period used by the generator
//   state_e        : receiver frame state (IDLE / SHIFT)
package m_spi_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int SCLK_DIV       = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/m_sync_edge.sv
// m_sync_edge: two-flop synchronizer for one asynchronous input plus a
// history flop for edge detection.
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset; all flops load RST_LVL
//   d_i     : asynchronous input
//   level_o : synchronized level (second sync flop)
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module m_sync_edge #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= RST_LVL;
            s2_q <= RST_LVL;
            s3_q <= RST_LVL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/m_spi_rx.sv
// m_spi_rx: oversampling receiver for the 3-wire DAC link (SCLK/SDIN/SYNC).
// All link inputs are asynchronous to CLK30. SDIN is sampled on SCLK falling
// edges while SYNC is low, MSB first; the frame outcome is registered when
// SYNC returns high.
//   CLK30     : system clock
//   RSTN      : asynchronous active-low reset
//   SCLK      : serial clock (async)
//   SDIN      : serial data (async)
//   SYNC      : active-low frame select (async)
//   DATA      : last good word
//   VALID     : one-cycle pulse when DATA updates
//   ERR       : one-cycle pulse on a malformed frame
//   ERR_LONG  : cause of the last ERR (1 = too many bits, 0 = too few)
//   BUSY      : high while a frame is open
//   FRAME_CNT : good frame count (wraps)
//   ERR_CNT   : bad frame count (wraps)
module m_spi_rx
    import m_spi_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK30,
    input  logic                  RSTN,
    input  logic                  SCLK,
    input  logic                  SDIN,
    input  logic                  SYNC,
    output logic [FRAME_BITS-1:0] DATA,
    output logic                  VALID,
    output logic                  ERR,
    output logic                  ERR_LONG,
    output logic                  BUSY,
    output logic [CNT_W-1:0]      FRAME_CNT,
    output logic [CNT_W-1:0]      ERR_CNT
);

    localparam int             BW   = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0]  FULL = BW'(FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sdin_lvl, sdin_rise, sdin_fall;
    logic sync_lvl, sync_rise, sync_fall;

    // Identical synchronizer depth on all three paths keeps sdin_lvl aligned
    // with the sclk_fall event it belongs to.
    m_sync_edge #(.RST_LVL(1'b0)) u_sclk (
        .clk_i(CLK30), .rst_ni(RSTN), .d_i(SCLK),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    m_sync_edge #(.RST_LVL(1'b0)) u_sdin (
        .clk_i(CLK30), .rst_ni(RSTN), .d_i(SDIN),
        .level_o(sdin_lvl), .rise_o(sdin_rise), .fall_o(sdin_fall)
    );
    m_sync_edge #(.RST_LVL(1'b1)) u_sync (
        .clk_i(CLK30), .rst_ni(RSTN), .d_i(SYNC),
        .level_o(sync_lvl), .rise_o(sync_rise), .fall_o(sync_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_rise, sdin_rise, sdin_fall};

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic                  ovf_q, ovf_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  elong_q, elong_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      ecnt_q, ecnt_d;

    // State register
    always_ff @(posedge CLK30 or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sync_fall) state_d = SHIFT;
            SHIFT:   if (sync_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / outputs
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        elong_d  = elong_q;
        busy_d   = busy_q;
        fcnt_d   = fcnt_q;
        ecnt_d   = ecnt_q;
        case (state_q)
            IDLE: begin
                if (sync_fall) begin
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (sync_rise) begin
                    busy_d = 1'b0;
                    if (bitcnt_q == FULL && !ovf_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + CNT_W'(1);
                    end else if (bitcnt_q != '0) begin
                        err_d   = 1'b1;
                        elong_d = ovf_q;
                        ecnt_d  = ecnt_q + CNT_W'(1);
                    end
                    // bitcnt == 0: SYNC glitch, nothing reported
                end else if (sclk_fall && !sync_lvl) begin
                    if (bitcnt_q < FULL) begin
                        shreg_d  = {shreg_q[FRAME_BITS-2:0], sdin_lvl};
                        bitcnt_d = bitcnt_q + BW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK30 or negedge RSTN) begin
        if (!RSTN) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            elong_q  <= 1'b0;
            busy_q   <= 1'b0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            elong_q  <= elong_d;
            busy_q   <= busy_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign ERR       = err_q;
    assign ERR_LONG  = elong_q;
    assign BUSY      = busy_q;
    assign FRAME_CNT = fcnt_q;
    assign ERR_CNT   = ecnt_q;

endmodule

// File: tb/tb_m_spi_rx.sv
// tb_m_spi_rx: drives the DAC link pins with framed words and checks the
// receiver against a frame-level model (bits taken -> outcome). A second
// instance with 4-bit counters shares the pins to observe counter wrap.
module tb_m_spi_rx;

    logic        CLK30 = 1'b0;
    logic        RSTN  = 1'b0;
    logic        SCLK  = 1'b0;
    logic        SDIN  = 1'b0;
    logic        SYNC  = 1'b1;

    logic [15:0] DATA, DATA4;
    logic        VALID, ERR, ERR_LONG, BUSY;
    logic        VALID4, ERR4, ERR_LONG4, BUSY4;
    logic [15:0] FRAME_CNT, ERR_CNT;
    logic [3:0]  FRAME_CNT4, ERR_CNT4;

    m_spi_rx #(.FRAME_BITS(16), .CNT_W(16)) u_dut (
        .CLK30(CLK30), .RSTN(RSTN), .SCLK(SCLK), .SDIN(SDIN), .SYNC(SYNC),
        .DATA(DATA), .VALID(VALID), .ERR(ERR), .ERR_LONG(ERR_LONG),
        .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
    );

    m_spi_rx #(.FRAME_BITS(16), .CNT_W(4)) u_dut4 (
        .CLK30(CLK30), .RSTN(RSTN), .SCLK(SCLK), .SDIN(SDIN), .SYNC(SYNC),
        .DATA(DATA4), .VALID(VALID4), .ERR(ERR4), .ERR_LONG(ERR_LONG4),
        .BUSY(BUSY4), .FRAME_CNT(FRAME_CNT4), .ERR_CNT(ERR_CNT4)
    );

    always #5 CLK30 = ~CLK30;

    int checks = 0;
    int errors = 0;

    // Pulse tallies over the whole run, used to prove silence in windows.
    int valid_tot = 0;
    int err_tot   = 0;
    always @(negedge CLK30) begin
        if (VALID || VALID4) valid_tot <= valid_tot + 1;
        if (ERR || ERR4)     err_tot   <= err_tot + 1;
    end

    // Frame-level model
    int          m_fcnt  = 0;
    int          m_ecnt  = 0;
    logic [15:0] m_data  = '0;
    logic        m_elong = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK30);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "/data"},  32'(DATA),      32'(m_data));
        chk({tag, "/elong"}, 32'(ERR_LONG),  32'(m_elong));
        chk({tag, "/busy"},  32'(BUSY),      32'd0);
        chk({tag, "/fcnt"},  32'(FRAME_CNT), 32'(m_fcnt % 65536));
        chk({tag, "/ecnt"},  32'(ERR_CNT),   32'(m_ecnt % 65536));
        chk({tag, "/fcnt4"}, 32'(FRAME_CNT4), 32'(m_fcnt % 16));
        chk({tag, "/ecnt4"}, 32'(ERR_CNT4),   32'(m_ecnt % 16));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/data"},  32'(DATA),      32'd0);
        chk({tag, "/valid"}, 32'(VALID),     32'd0);
        chk({tag, "/err"},   32'(ERR),       32'd0);
        chk({tag, "/elong"}, 32'(ERR_LONG),  32'd0);
        chk({tag, "/busy"},  32'(BUSY),      32'd0);
        chk({tag, "/fcnt"},  32'(FRAME_CNT), 32'd0);
        chk({tag, "/ecnt"},  32'(ERR_CNT),   32'd0);
    endtask

    task automatic model_reset();
        m_fcnt  = 0;
        m_ecnt  = 0;
        m_data  = '0;
        m_elong = 1'b0;
    endtask

    // Send one SYNC-low window carrying nbits of 'bits' MSB first with SCLK
    // half-period 'half'. With coinc set, the last SCLK fall is driven in the
    // same instant as SYNC rise, so that bit must not be counted.
    task automatic run_frame(input string tag, input logic [31:0] bits, input int nbits,
                             input int half, input bit coinc);
        int          taken;
        logic [15:0] val;
        int          vcnt, ecnt, vfirst, efirst, both;
        logic [15:0] vdata;
        int          exp_v, exp_e;
        taken = 0;
        val   = '0;
        SYNC  = 1'b0;
        SDIN  = 1'b0;
        wait_cyc(half);
        if (nbits > 0) chk({tag, "/busy_open"}, 32'(BUSY), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b1;
            SDIN = bits[nbits-1-i];
            wait_cyc(half);
            SCLK = 1'b0;
            if (coinc && i == nbits - 1) begin
                SYNC = 1'b1;
            end else begin
                taken++;
                if (taken <= 16) val = 16'(val * 2 + 32'(bits[nbits-1-i]));
                wait_cyc(half);
            end
        end
        SYNC = 1'b1;

        vcnt = 0; ecnt = 0; vfirst = 0; efirst = 0; both = 0; vdata = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK30);
            @(negedge CLK30);
            if (VALID) begin
                vcnt++;
                if (vfirst == 0) vfirst = k;
                vdata = DATA;
            end
            if (ERR) begin
                ecnt++;
                if (efirst == 0) efirst = k;
            end
            if (VALID && ERR) both++;
        end

        exp_v = 0;
        exp_e = 0;
        if (taken == 16) begin
            exp_v  = 1;
            m_data = val;
            m_fcnt++;
        end else if (taken != 0) begin
            exp_e   = 1;
            m_elong = (taken > 16);
            m_ecnt++;
        end

        chk({tag, "/nvalid"}, 32'(vcnt), 32'(exp_v));
        chk({tag, "/nerr"},   32'(ecnt), 32'(exp_e));
        chk({tag, "/both"},   32'(both), 32'd0);
        if (exp_v != 0) begin
            chk({tag, "/vlat"},  32'(vfirst), 32'd3);
            chk({tag, "/vdata"}, 32'(vdata),  32'(val));
        end
        if (exp_e != 0) chk({tag, "/elat"}, 32'(efirst), 32'd3);
        chk_state(tag);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        SYNC = 1'b1;
        SCLK = 1'b0;
        SDIN = 1'b0;
        wait_cyc(3);
        model_reset();
        RSTN = 1'b1;
        wait_cyc(4);
    endtask

    initial begin
        int          v0, e0, nb, hf;
        bit          co;
        logic [31:0] w;

        // Reset with idle inputs
        wait_cyc(3);
        chk_zero("rst");
        RSTN = 1'b1;
        v0 = valid_tot;
        e0 = err_tot;
        for (int i = 0; i < 200; i++) begin
            if (i % 8 == 0) SCLK = ~SCLK;
            wait_cyc(1);
        end
        SCLK = 1'b0;
        wait_cyc(4);
        chk("idle/pulses", 32'(valid_tot - v0 + err_tot - e0), 32'd0);
        chk_state("idle");

        // Single known word at generator rate
        run_frame("a5c3", 32'h0000_A5C3, 16, 8, 1'b0);

        // Generator-format frames: 3 zero bits, 11-bit phase, 2 zero bits
        for (int f = 0; f < 10; f++)
            run_frame("gen", {16'h0, 3'b000, 11'h5A3, 2'b00}, 16, 8, 1'b0);
        chk("gen/data", 32'(DATA), 32'h168C);

        // Malformed and degenerate frames
        run_frame("short", 32'h0000_0ABC, 12, 8, 1'b0);
        run_frame("long",  32'h0003_1F0F, 18, 8, 1'b0);
        run_frame("glitch", 32'h0, 0, 2, 1'b0);

        // Last fall coincides with SYNC rise: 16 earlier bits form the word
        run_frame("coinc", 32'h0001_3579, 17, 6, 1'b1);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            w  = $urandom;
            nb = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(1, 20));
            hf = int'($urandom_range(3, 8));
            co = ($urandom_range(0, 4) == 0);
            run_frame("rnd", w, nb, hf, co);
        end

        // Reset mid-frame after 8 bits
        v0 = valid_tot;
        e0 = err_tot;
        SYNC = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b1;
            SDIN = 1'(i & 1);
            wait_cyc(6);
            SCLK = 1'b0;
            wait_cyc(6);
        end
        RSTN = 1'b0;
        wait_cyc(2);
        SYNC = 1'b1;
        chk_zero("midrst");
        wait_cyc(2);
        model_reset();
        RSTN = 1'b1;
        wait_cyc(8);
        chk("midrst/pulses", 32'(valid_tot - v0 + err_tot - e0), 32'd0);
        run_frame("post", 32'h0000_1234, 16, 8, 1'b0);
        chk("post/data", 32'(DATA), 32'h1234);
        chk("post/fcnt", 32'(FRAME_CNT), 32'd1);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int f = 0; f < 17; f++) run_frame("wrap", $urandom, 16, 4, 1'b0);
        chk("wrap/fcnt4", 32'(FRAME_CNT4), 32'd1);
        chk("wrap/fcnt",  32'(FRAME_CNT),  32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
